// File: rtl/kronos_ssd_ctrl_if.sv
// Bus interface between the Kronos data bus and the PmodSSD driver.
// master: drives address/request/write controls and write data; receives read data and ack.
// slave : receives address/request/write controls; returns read data and ack.
interface kronos_ssd_ctrl_if;
  logic [3:0]  data_addr;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic [31:0] data_rd_data;
  logic        data_ack;

  modport master (
    output data_addr, data_req, data_we, data_wr_data, data_mask,
    input  data_rd_data, data_ack
  );

  modport slave (
    input  data_addr, data_req, data_we, data_wr_data, data_mask,
    output data_rd_data, data_ack
  );
endinterface

// File: rtl/kronos_ssd_ctrl.sv
// Memory-mapped driver for the dual-digit PmodSSD.
// Firmware writes VALUE (two hex nibbles) and CTRL (EN, BLINK); the block
// alternates CAT between the two digits and drives the decoded segments.
// Ports:
//   clk   - system clock
//   rstz  - asynchronous active-low reset
//   bus   - slave side of the data bus (addr/req/we/wr_data/mask in, rd_data/ack out)
//   CAT   - digit select: 0 = right digit (VALUE[3:0]), 1 = left digit (VALUE[7:4])
//   seg   - active-high segments, seg[0]=AA .. seg[6]=AG
module kronos_ssd_ctrl #(
  parameter int REFRESH_DIV = 1024,
  parameter int BLINK_DIV   = 256
) (
  input  logic                     clk,
  input  logic                     rstz,
  kronos_ssd_ctrl_if.slave         bus,
  output logic                     CAT,
  output logic [6:0]               seg
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_t;

  // Hex digit to gfedcba segment pattern.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  bus_state_t      state_r, state_nxt_s;
  logic            accept_s;
  logic            ack_s;
  logic [7:0]      value_r, value_nxt_s;
  logic [1:0]      ctrl_r, ctrl_nxt_s;
  logic [31:0]     rd_data_r, rd_data_nxt_s;
  logic [RW-1:0]   rcnt_r, rcnt_nxt_s;
  logic            wrap_s;
  logic            cat_r, cat_nxt_s;
  logic [BW-1:0]   bcnt_r, bcnt_nxt_s;
  logic            blink_on_r, blink_on_nxt_s;
  logic [6:0]      seg_r, seg_nxt_s;
  logic            blank_s;

  // Bus handshake state register.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Bus handshake next state: a request seen in IDLE is acked next cycle,
  // and the ack cycle always returns to IDLE, so a held req is not re-sampled.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.data_req) state_nxt_s = ST_ACK;
        else              state_nxt_s = ST_IDLE;
      end
      ST_ACK:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Bus handshake outputs.
  always_comb begin
    accept_s = 1'b0;
    ack_s    = 1'b0;
    case (state_r)
      ST_IDLE: accept_s = bus.data_req;
      ST_ACK:  ack_s    = 1'b1;
      default: begin
        accept_s = 1'b0;
        ack_s    = 1'b0;
      end
    endcase
  end

  // Register writes (lane 0 only) and registered read data.
  always_comb begin
    value_nxt_s   = value_r;
    ctrl_nxt_s    = ctrl_r;
    rd_data_nxt_s = 32'h0000_0000;
    if (accept_s && bus.data_we) begin
      if (bus.data_mask[0]) begin
        case (bus.data_addr[3:2])
          2'd0:    value_nxt_s = bus.data_wr_data[7:0];
          2'd1:    ctrl_nxt_s  = bus.data_wr_data[1:0];
          default: value_nxt_s = value_r;
        endcase
      end else begin
        value_nxt_s = value_r;
      end
    end else if (accept_s) begin
      case (bus.data_addr[3:2])
        2'd0:    rd_data_nxt_s = {24'h00_0000, value_r};
        2'd1:    rd_data_nxt_s = {30'h0000_0000, ctrl_r};
        default: rd_data_nxt_s = 32'h0000_0000;
      endcase
    end else begin
      rd_data_nxt_s = 32'h0000_0000;
    end
  end

  // Refresh counter, digit select and blink phase.
  always_comb begin
    wrap_s     = (rcnt_r == REFRESH_LAST);
    rcnt_nxt_s = wrap_s ? '0 : rcnt_r + 1'b1;
    cat_nxt_s  = wrap_s ? ~cat_r : cat_r;
    bcnt_nxt_s     = bcnt_r;
    blink_on_nxt_s = blink_on_r;
    // Blink phase follows the CTRL value being committed this cycle so that
    // clearing BLINK takes effect on the same edge as the write.
    if (!ctrl_nxt_s[1]) begin
      bcnt_nxt_s     = '0;
      blink_on_nxt_s = 1'b1;
    end else if (wrap_s) begin
      if (bcnt_r == BLINK_LAST) begin
        bcnt_nxt_s     = '0;
        blink_on_nxt_s = ~blink_on_r;
      end else begin
        bcnt_nxt_s = bcnt_r + 1'b1;
      end
    end else begin
      bcnt_nxt_s = bcnt_r;
    end
  end

  // Segment pattern from next-cycle state, so writes and wraps land together.
  always_comb begin
    blank_s = !ctrl_nxt_s[0] || (ctrl_nxt_s[1] && !blink_on_nxt_s);
    if (blank_s) seg_nxt_s = 7'h00;
    else         seg_nxt_s = hex7(cat_nxt_s ? value_nxt_s[7:4] : value_nxt_s[3:0]);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      value_r    <= 8'h00;
      ctrl_r     <= 2'b00;
      rd_data_r  <= 32'h0000_0000;
      rcnt_r     <= '0;
      cat_r      <= 1'b0;
      bcnt_r     <= '0;
      blink_on_r <= 1'b1;
      seg_r      <= 7'h00;
    end else begin
      value_r    <= value_nxt_s;
      ctrl_r     <= ctrl_nxt_s;
      rd_data_r  <= rd_data_nxt_s;
      rcnt_r     <= rcnt_nxt_s;
      cat_r      <= cat_nxt_s;
      bcnt_r     <= bcnt_nxt_s;
      blink_on_r <= blink_on_nxt_s;
      seg_r      <= seg_nxt_s;
    end
  end

  assign bus.data_ack     = ack_s;
  assign bus.data_rd_data = rd_data_r;
  assign CAT              = cat_r;
  assign seg              = seg_r;

endmodule
